// File: rtl/store_buffer.sv
// store_buffer: in-order committed-store FIFO draining to the dCache, with load lookup.
// Define STORE_BUFFER_FORWARD_EN to forward store data to loads; otherwise any match stalls the load.
module store_buffer #(
  parameter int ARCH_BITS   = 32,
  parameter int SB_ENTRIES  = 4,
  parameter int SB_IDX_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_valid,
  input  logic [ARCH_BITS-1:0] enq_addr,
  input  logic [ARCH_BITS-1:0] enq_data,
  input  logic                 enq_byte,
  output logic                 full,
  output logic                 empty,
  input  logic [ARCH_BITS-1:0] ld_addr,
  input  logic                 ld_byte,
  input  logic                 ld_valid,
  output logic                 ld_hit,
  output logic [ARCH_BITS-1:0] ld_data,
  output logic                 ld_conflict,
  input  logic                 dc_busy,
  output logic                 dc_wreq,
  output logic [ARCH_BITS-1:0] dc_addr,
  output logic [ARCH_BITS-1:0] dc_wdata,
  output logic                 dc_wbyte,
  input  logic                 dc_wack
);
  localparam int CW = SB_IDX_BITS + 1;
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_q, state_d;
  logic [SB_ENTRIES-1:0] valid_q, valid_d, wbyte_q, wbyte_d;
  logic [ARCH_BITS-1:0] addr_q [SB_ENTRIES];
  logic [ARCH_BITS-1:0] addr_d [SB_ENTRIES];
  logic [ARCH_BITS-1:0] data_q [SB_ENTRIES];
  logic [ARCH_BITS-1:0] data_d [SB_ENTRIES];
  logic [SB_IDX_BITS-1:0] head_q, head_d, tail_q, tail_d, nxt, sel, idx, ld_sel;
  logic [CW-1:0] count_q, count_d;
  logic dc_wreq_q, dc_wreq_d, dc_wbyte_q, dc_wbyte_d;
  logic [ARCH_BITS-1:0] dc_addr_q, dc_addr_d, dc_wdata_q, dc_wdata_d;
  logic push, pop, load, ld_match;
  assign full     = count_q == CW'(SB_ENTRIES);
  assign empty    = count_q == '0;
  assign push     = enq_valid && !full;
  assign pop      = state_q == WRITE && dc_wack;
  assign nxt      = head_q + SB_IDX_BITS'(1);
  // Start a drain from IDLE, or chain straight into the next entry after an ack.
  assign load     = !dc_busy && (state_q == IDLE ? !empty : pop && count_q > CW'(1));
  assign sel      = state_q == IDLE ? head_q : nxt;
  assign dc_wreq  = dc_wreq_q;
  assign dc_addr  = dc_addr_q;
  assign dc_wdata = dc_wdata_q;
  assign dc_wbyte = dc_wbyte_q;
  always_comb begin
    valid_d    = valid_q;
    wbyte_d    = wbyte_q;
    addr_d     = addr_q;
    data_d     = data_q;
    head_d     = pop ? nxt : head_q;
    tail_d     = push ? tail_q + SB_IDX_BITS'(1) : tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    state_d    = load ? WRITE : pop ? IDLE : state_q;
    dc_wreq_d  = load ? 1'b1 : pop ? 1'b0 : dc_wreq_q;
    dc_addr_d  = load ? addr_q[sel] : dc_addr_q;
    dc_wdata_d = load ? data_q[sel] : dc_wdata_q;
    dc_wbyte_d = load ? wbyte_q[sel] : dc_wbyte_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      wbyte_d[tail_q] = enq_byte;
      addr_d[tail_q]  = enq_addr;
      data_d[tail_q]  = enq_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      dc_wreq_q  <= 1'b0;
      dc_addr_q  <= '0;
      dc_wdata_q <= '0;
      dc_wbyte_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      dc_wreq_q  <= dc_wreq_d;
      dc_addr_q  <= dc_addr_d;
      dc_wdata_q <= dc_wdata_d;
      dc_wbyte_q <= dc_wbyte_d;
    end
  end
  always_ff @(posedge clk) begin
    wbyte_q <= wbyte_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
  end
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    ld_match = 1'b0;
    ld_sel   = '0;
    idx      = '0;
    for (int i = 0; i < SB_ENTRIES; i++) begin
      idx = head_q + SB_IDX_BITS'(i);
      if (valid_q[idx] && addr_q[idx][ARCH_BITS-1:2] == ld_addr[ARCH_BITS-1:2]) begin
        ld_match = 1'b1;
        ld_sel   = idx;
      end
    end
  end
`ifdef STORE_BUFFER_FORWARD_EN
  logic [ARCH_BITS-1:0] sel_data;
  logic [7:0] ld_b;
  logic fwd_ok;
  always_comb begin
    sel_data = data_q[ld_sel];
    ld_b     = wbyte_q[ld_sel] ? sel_data[7:0] : 8'(sel_data >> {ld_addr[1:0], 3'b000});
    fwd_ok   = !wbyte_q[ld_sel] || (ld_byte && addr_q[ld_sel][1:0] == ld_addr[1:0]);
  end
  assign ld_hit      = ld_valid && ld_match && fwd_ok;
  assign ld_conflict = ld_valid && ld_match && !fwd_ok;
  assign ld_data     = !ld_hit ? '0 : ld_byte ? {{(ARCH_BITS-8){1'b0}}, ld_b} : sel_data;
`else
  logic unused_ld;
  assign unused_ld   = ^{ld_byte, ld_addr[1:0], ld_sel};
  assign ld_hit      = 1'b0;
  assign ld_conflict = ld_valid && ld_match;
  assign ld_data     = '0;
`endif
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO that holds committed stores (STB/STW) retired in order by the reorder buffer and drains them into the data cache one at a time over a write handshake.
- Searches buffered entries combinationally for in-flight loads in the dCache stage, so a load returns the youngest matching store data or reports a conflict that stalls it.
- Sits between the ROB commit port and the dCache write port.

Parameters:
- ARCH_BITS, 32, address/data width
- SB_ENTRIES, 4, number of entries (power of two)
- SB_IDX_BITS, 2, log2(SB_ENTRIES)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enq_valid  in  1  ROB commits a store this cycle
- enq_addr  in  ARCH_BITS  store byte address
- enq_data  in  ARCH_BITS  store data (STB uses bits [7:0])
- enq_byte  in  1  1=STB, 0=STW
- full  out  1  no free entry
- empty  out  1  no valid entry
- ld_addr  in  ARCH_BITS  load address under lookup
- ld_byte  in  1  1=LDB, 0=LDW
- ld_valid  in  1  lookup request
- ld_hit  out  1  buffer supplies full load data
- ld_data  out  ARCH_BITS  forwarded data
- ld_conflict  out  1  matching store cannot supply data; load must stall
- dc_busy  in  1  dCache serving a pipeline access; no new drain may start
- dc_wreq  out  1  drain write request
- dc_addr  out  ARCH_BITS  drain address
- dc_wdata  out  ARCH_BITS  drain data
- dc_wbyte  out  1  drain is byte store
- dc_wack  in  1  dCache accepted the write

Behaviour:
- Storage: circular array of {valid, addr, data, byte}; head (oldest), tail, count of SB_IDX_BITS+1 bits. Pointers wrap modulo SB_ENTRIES.
- Reset: head=tail=count=0, all valid=0, dc_wreq=0, dc_addr=0, dc_wdata=0, dc_wbyte=0, FSM=IDLE. Outputs after reset: full=0, empty=1, ld_hit=0, ld_conflict=0, ld_data=0.
- full = (count==SB_ENTRIES); empty = (count==0). Both derive from registered count only.
- Enqueue: when enq_valid && !full, write the entry at tail and advance tail next edge. When enq_valid && full, drop the store; it is not written. The ROB must not commit a store while full.
- Simultaneous enqueue and pop (pop means dc_wack in WRITE): count is unchanged and both pointers advance. When full, enqueue is still rejected that cycle even if a pop occurs.
- Drain FSM:
  - IDLE: if !empty && !dc_busy, register the head entry into dc_addr/dc_wdata/dc_wbyte, set dc_wreq=1, go to WRITE. Otherwise stay.
  - WRITE: hold dc_wreq and data stable until dc_wack. On dc_wack, clear valid[head], advance head, decrement count.
    - If another entry remains and !dc_busy, load the next head and stay in WRITE with dc_wreq=1 continuously (back-to-back drain).
    - Otherwise drop dc_wreq and go to IDLE.
  - dc_busy is ignored once in WRITE.
- A draining entry stays valid and searchable until dc_wack.
- Lookup (combinational, ld_valid=1): compare ld_addr[31:2] with every valid entry and select the youngest match (nearest tail).
  - No match: ld_hit=0, ld_conflict=0.
  - Youngest match is STW: ld_hit=1. LDW returns its data. LDB returns the byte selected by ld_addr[1:0] (little-endian, byte 0 = bits[7:0]), zero-extended.
  - Youngest match is STB at the same byte address and load is LDB: ld_hit=1, ld_data={24'b0, data[7:0]}.
  - Any other match (LDW over STB, or LDB over STB at a different byte): ld_conflict=1, ld_hit=0.
  - With ld_valid=0: ld_hit=0, ld_conflict=0, ld_data=0.
- Reset mid-drain discards all entries and drops dc_wreq the next cycle. Committed stores not yet drained are lost, which is acceptable only at reset.

Optional Feature:
- Macro STORE_BUFFER_FORWARD_EN.
- Defined: forwarding as specified above.
- Undefined: ld_hit is tied to 0, and any word-address match with a valid entry raises ld_conflict=1. Loads stall until the matching stores drain. Lookup mux logic is removed.

Test Plan:
- Reset, then enqueue STW 0x100←0xDEADBEEF with dc_busy=0 -> dc_wreq=1 next cycle with dc_addr=0x100; ack after 3 cycles -> empty=1, dc_wreq=0 the following cycle.
- Enqueue 4 STWs with dc_busy=1 -> full=1; a 5th enq_valid is dropped (count stays 4); release dc_busy and ack each -> 4 writes in FIFO order, dc_wreq held continuously.
- STW 0x200←0x11223344 then STW 0x200←0xAABBCCDD buffered; LDW 0x200 -> ld_hit=1, ld_data=0xAABBCCDD; LDB 0x201 -> ld_data=0x000000CC.
- STB 0x300←0x5A buffered; LDB 0x300 -> hit, data 0x0000005A; LDW 0x300 -> ld_conflict=1; LDB 0x302 -> ld_conflict=1.
- At full with dc_wack and enq_valid in the same cycle -> pop occurs, enqueue rejected, count=3; head and tail wrap correctly after 6 enqueue/drain pairs.
- Assert rst during WRITE with 3 entries -> next cycle dc_wreq=0, empty=1, full=0; with STORE_BUFFER_FORWARD_EN undefined, the 0x200 scenario gives ld_conflict=1, ld_hit=0.
